// File: rtl/block_writer.sv
// block_writer: turns open/close/word/close-all commands into a space-terminated
// "begin"/"end"/single-character word stream. Optional macro: BLOCK_WRITER_CLOSE_ALL_EN.
module block_writer #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_arg,
  output logic               cmd_ready,
  output logic               out_valid,
  output logic [7:0]         out_char,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef enum logic [1:0] {
    K_BEGIN = 2'b00,
    K_END   = 2'b01,
    K_WORD  = 2'b10,
    K_CLOSE = 2'b11
  } kind_t;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t             state, state_n;
  kind_t              kind, kind_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         arg, arg_n;
  logic [7:0]         char_q, char_n;
  logic [DEPTH_W-1:0] depth_q, depth_n;
  logic               err_q, err_n;
  logic               accept;
  logic               fire;
  logic               last_byte;

  function automatic logic [2:0] word_len(input kind_t k);
    case (k)
      K_BEGIN: word_len = 3'd6;
      K_WORD:  word_len = 3'd2;
      default: word_len = 3'd4;
    endcase
  endfunction

  // Byte i of the word being emitted; WORD words take their character from the latched argument.
  function automatic logic [7:0] word_byte(input kind_t k, input logic [2:0] i, input logic [7:0] a);
    word_byte = SPACE;
    case (k)
      K_BEGIN:
        case (i)
          3'd0:    word_byte = 8'h62;
          3'd1:    word_byte = 8'h65;
          3'd2:    word_byte = 8'h67;
          3'd3:    word_byte = 8'h69;
          3'd4:    word_byte = 8'h6E;
          default: word_byte = SPACE;
        endcase
      K_WORD:
        word_byte = (i == 3'd0) ? a : SPACE;
      default:
        case (i)
          3'd0:    word_byte = 8'h65;
          3'd1:    word_byte = 8'h6E;
          3'd2:    word_byte = 8'h64;
          default: word_byte = SPACE;
        endcase
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      kind    <= K_BEGIN;
      idx     <= 3'd0;
      arg     <= SPACE;
      char_q  <= SPACE;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      kind    <= kind_n;
      idx     <= idx_n;
      arg     <= arg_n;
      char_q  <= char_n;
      depth_q <= depth_n;
      err_q   <= err_n;
    end
  end

  assign accept    = cmd_valid && (state == IDLE);
  assign fire      = (state == EMIT) && out_ready;
  assign last_byte = (idx == (word_len(kind) - 3'd1));

  // Legality is decided at acceptance; illegal commands only touch err and leave the FSM idle.
  always_comb begin
    state_n = state;
    kind_n  = kind;
    idx_n   = idx;
    arg_n   = arg;
    char_n  = char_q;
    depth_n = depth_q;
    err_n   = err_q;

    if (accept) begin
      case (cmd_op)
        2'b00: begin
          if (depth_q == DEPTH_MAX) begin
            err_n = 1'b1;
          end else begin
            depth_n = depth_q + DEPTH_ONE;
            kind_n  = K_BEGIN;
            idx_n   = 3'd0;
            char_n  = word_byte(K_BEGIN, 3'd0, arg);
            state_n = EMIT;
          end
        end
        2'b01: begin
          if (depth_q == '0) begin
            err_n = 1'b1;
          end else begin
            depth_n = depth_q - DEPTH_ONE;
            kind_n  = K_END;
            idx_n   = 3'd0;
            char_n  = word_byte(K_END, 3'd0, arg);
            state_n = EMIT;
          end
        end
        2'b10: begin
          if (cmd_arg == SPACE) begin
            err_n = 1'b1;
          end else begin
            arg_n   = cmd_arg;
            kind_n  = K_WORD;
            idx_n   = 3'd0;
            char_n  = cmd_arg;
            state_n = EMIT;
          end
        end
        default: begin
`ifdef BLOCK_WRITER_CLOSE_ALL_EN
          if (depth_q != '0) begin
            kind_n  = K_CLOSE;
            idx_n   = 3'd0;
            char_n  = word_byte(K_CLOSE, 3'd0, arg);
            state_n = EMIT;
          end
`else
          err_n = 1'b1;
`endif
        end
      endcase
    end else if (fire) begin
      if (!last_byte) begin
        idx_n  = idx + 3'd1;
        char_n = word_byte(kind, idx + 3'd1, arg);
      end else begin
        idx_n   = 3'd0;
        char_n  = SPACE;
        state_n = IDLE;
`ifdef BLOCK_WRITER_CLOSE_ALL_EN
        // Close-all closes one level per finished "end " and restarts until depth hits zero.
        if (kind == K_CLOSE) begin
          depth_n = depth_q - DEPTH_ONE;
          if (depth_q != DEPTH_ONE) begin
            char_n  = word_byte(K_CLOSE, 3'd0, arg);
            state_n = EMIT;
          end
        end
`endif
      end
    end
  end

  assign cmd_ready = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_char  = char_q;
  assign depth     = depth_q;
  assign err       = err_q;
  assign balanced  = (depth_q == '0) && (state == IDLE);

endmodule

// File: tb/tb_block_writer.sv
// Self-checking bench for block_writer: directed scenarios plus random command
// streams checked against a queue-of-expected-bytes model.
module tb_block_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;
  logic [7:0] depth;
  logic       err;
  logic       balanced;

  block_writer #(.DEPTH_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_ready (out_ready),
    .depth     (depth),
    .err       (err),
    .balanced  (balanced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         dec;
  } exp_byte_t;

  exp_byte_t exp_q[$];
  int        m_depth;
  bit        m_err;
  int        checks;
  int        passes;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic push_text(input string s, input bit dec_on_last);
    exp_byte_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch  = s[i];
      e.dec = dec_on_last && (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  // What the writer should do with a command it accepts, stated in terms of words and depth.
  task automatic model_accept(input logic [1:0] op, input logic [7:0] a);
    exp_byte_t e;
    case (op)
      2'b00: if (m_depth == 255) m_err = 1; else begin m_depth++; push_text("begin ", 0); end
      2'b01: if (m_depth == 0) m_err = 1; else begin m_depth--; push_text("end ", 0); end
      2'b10: begin
        if (a == 8'h20) m_err = 1;
        else begin
          e.ch = a; e.dec = 0; exp_q.push_back(e);
          e.ch = 8'h20; exp_q.push_back(e);
        end
      end
      default: begin
`ifdef BLOCK_WRITER_CLOSE_ALL_EN
        for (int i = 0; i < m_depth; i++) push_text("end ", 1);
`else
        m_err = 1;
`endif
      end
    endcase
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_depth = 0;
    m_err   = 0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model across the rising edge.
  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] a, input bit rdy);
    bit idle;
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = a;
    out_ready = rdy;
    #1;
    idle = (exp_q.size() == 0);
    checkOutput("cmd_ready", cmd_ready, idle);
    checkOutput("out_valid", out_valid, !idle);
    checkOutput("depth", depth, m_depth);
    checkOutput("err", err, m_err);
    checkOutput("balanced", balanced, (m_depth == 0) && idle);
    if (!idle) checkOutput("out_char", out_char, exp_q[0].ch);
    if (idle && v) model_accept(op, a);
    else if (!idle && rdy) begin
      if (exp_q[0].dec) m_depth--;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // Issue one command and drain its output; rmode 0 holds out_ready high, 1 randomises it.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input bit rmode);
    int budget;
    step(1, op, a, rmode ? bit'($urandom_range(0, 1)) : 1'b1);
    budget = 5000;
    while (exp_q.size() != 0 && budget > 0) begin
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           rmode ? bit'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    if (budget == 0) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_char", out_char, 8'h20);
    checkOutput("rst_depth", depth, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_balanced", balanced, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] a;
    checks = 0;
    passes = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_arg = 8'h00;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    $display("[TB] begin with out_ready high");
    applyStimulus(2'b00, 8'h00, 0);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] end from reset");
    do_reset();
    applyStimulus(2'b01, 8'h00, 0);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] begin with stall on third byte");
    do_reset();
    step(1, 2'b00, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);
    repeat (3) step(1, 2'b01, 8'h00, 0);
    while (exp_q.size() != 0) step(0, 2'b00, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] word commands");
    do_reset();
    applyStimulus(2'b10, 8'h71, 0);
    applyStimulus(2'b10, 8'h20, 0);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] close-all after three begins");
    do_reset();
    repeat (3) applyStimulus(2'b00, 8'h00, 0);
    applyStimulus(2'b11, 8'h00, 0);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] reset during third byte");
    do_reset();
    step(1, 2'b00, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);
    do_reset();
    applyStimulus(2'b01, 8'h00, 0);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] random command stream");
    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int n = 0; n < 80; n++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: op = 2'b00;
          4, 5, 6:    op = 2'b01;
          7, 8:       op = 2'b10;
          default:    op = 2'b11;
        endcase
        a = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'($urandom_range(8'h61, 8'h7A));
        applyStimulus(op, a, 1);
        repeat ($urandom_range(0, 2)) step(0, 2'b00, 8'h00, bit'($urandom_range(0, 1)));
      end
    end

    $display("[TB] depth saturation");
    do_reset();
    repeat (255) applyStimulus(2'b00, 8'h00, 0);
    applyStimulus(2'b00, 8'h00, 0);
    applyStimulus(2'b11, 8'h00, 0);
    applyStimulus(2'b01, 8'h00, 1);
    step(0, 2'b00, 8'h00, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/block_writer.md
# block_writer

Character-stream generator for the block-nesting text format: turns a command stream (open block, close block, filler word, close-all) into a space-terminated ASCII word stream of `begin` / `end` / single-character words. It emits one byte per handshake and tracks nesting depth, so any stream it produces without raising `err` is accepted as balanced by the block checker. It is the transmit-side counterpart to the checker and sits between a test or command source and the checker's `in` byte input.

## Interface
- `DEPTH_W`, 8, width of the nesting-depth counter; maximum depth is 2^DEPTH_W−1.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  operation: 00 BEGIN, 01 END, 10 WORD, 11 CLOSE_ALL.
- `cmd_arg`  in  8  character for WORD; ignored otherwise.
- `cmd_ready`  out  1  block can accept a command.
- `out_valid`  out  1  `out_char` valid.
- `out_char`  out  8  emitted ASCII byte, lowercase.
- `out_ready`  in  1  consumer accepts `out_char`.
- `depth`  out  DEPTH_W  current open-block count.
- `err`  out  1  sticky: an illegal command was rejected.
- `balanced`  out  1  `depth == 0` and no emission in progress.

## Operation
- Two-state FSM: IDLE and EMIT. `cmd_ready = (state == IDLE)`. A command is accepted on any edge with `cmd_valid && cmd_ready`.
- Legality is checked at acceptance. A legal command moves the FSM to EMIT. An illegal command is consumed, sets `err`, produces no output, and leaves the FSM in IDLE.
  - BEGIN: illegal if `depth` is at its maximum. Otherwise `depth` increments at acceptance and the block emits `b e g i n ␠` (6 bytes).
  - END: illegal if `depth == 0`. Otherwise `depth` decrements at acceptance and the block emits `e n d ␠` (4 bytes).
  - WORD: illegal if `cmd_arg == 8'h20`. Otherwise it emits `cmd_arg` then `␠` (2 bytes). `cmd_arg` is latched at acceptance, and `depth` is unchanged.
  - CLOSE_ALL: see Configuration.
- In EMIT, a byte index selects the byte from the latched word. The index advances only on `out_valid && out_ready`.
- After the handshake of the terminating space, the FSM returns to IDLE.
- `err` is cleared only by `reset`.
- `depth` arithmetic is unsigned and never wraps; the legality checks guarantee this.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `out_valid` 0, `out_char` 8'h20, `depth` 0, `err` 0, `balanced` 1.
- Latency:
  - The first byte is valid in the cycle after acceptance.
  - With `out_ready` held high, a word of N bytes occupies N consecutive cycles.
  - `cmd_ready` is high again in the cycle after the final byte's handshake, so back-to-back BEGINs give one idle cycle per word.
- Handshake rules:
  - `out_char` is registered and held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
- Deassertion of `cmd_valid` while `cmd_ready` is low has no effect.
- `depth` and `err` update on the acceptance edge. `balanced` is combinational from registered state.
- Reset mid-emission aborts immediately: the partial word is discarded and all outputs return to their reset values asynchronously.

## Configuration
- Macro `BLOCK_WRITER_CLOSE_ALL_EN`.
- Defined:
  - CLOSE_ALL with `depth == 0` is accepted with no output and no error.
  - Otherwise it enters EMIT and repeats `e n d ␠` until `depth` reaches 0.
  - `depth` decrements on each terminating-space handshake, not at acceptance.
  - `cmd_ready` stays low until the last `end ␠` completes.
- Undefined: op 11 is illegal. It is consumed, sets `err`, and produces no output.

## Test plan
- Reset, then BEGIN with `out_ready`=1 → bytes 0x62,0x65,0x67,0x69,0x6E,0x20 on 6 consecutive cycles starting the cycle after acceptance; `depth`=1 from the acceptance edge; `balanced`=0.
- From reset, END → no `out_valid`, `err`=1, `depth`=0, `cmd_ready` high next cycle.
- BEGIN with `out_ready` low for 3 cycles while 0x67 is presented → 0x67 held stable with `out_valid`=1; the sequence resumes unchanged after release.
- WORD `cmd_arg`=0x71 → 0x71, 0x20. WORD `cmd_arg`=0x20 → no output, `err`=1.
- With macro defined: 3×BEGIN, then CLOSE_ALL → 12 bytes "end end end ", `depth` 3→2→1→0, then `balanced`=1. Without macro: CLOSE_ALL → `err`=1, `depth` stays 3.
- Assert `reset` during the 3rd byte of BEGIN → `out_valid`=0, `depth`=0, `cmd_ready`=1 immediately; a subsequent END sets `err`.
